// File: rtl/blit_engine.sv
// Rectangle blitter: copies a w x h region from a synchronous source memory
// to the VGA write port at one pixel per clock.
// Modes: COPY, KEY (colour-key transparency), SHADOW (black where opaque),
// FILL (solid colour). Optional horizontal flip and screen clipping.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   go                  start request, sampled only when idle
//   src_base/stride     source origin and words per row
//   blit_w/blit_h       region size in pixels
//   dst_x/dst_y         screen position of the top-left corner
//   mode/flip_x         operation mode and horizontal mirror
//   fill_colour         colour used in FILL mode
//   src_addr/src_rd     source read request
//   src_data            source data, READ_LATENCY clocks after the address
//   X_out/Y_out/colour  pixel write coordinates and colour
//   write_en            pixel write strobe
//   busy/done           operation in progress / one-cycle completion pulse
module blit_engine #(
   parameter int unsigned COLOUR_BITS  = 6,
   parameter int unsigned X_BITS       = 9,
   parameter int unsigned Y_BITS       = 8,
   parameter int unsigned SCREEN_W     = 320,
   parameter int unsigned SCREEN_H     = 240,
   parameter int unsigned SRC_AW       = 17,
   parameter int unsigned DIM_BITS     = 9,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [COLOUR_BITS-1:0] TRANSPARENT = 6'b001100
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   go,
   input  logic [SRC_AW-1:0]      src_base,
   input  logic [DIM_BITS-1:0]    src_stride,
   input  logic [DIM_BITS-1:0]    blit_w,
   input  logic [DIM_BITS-1:0]    blit_h,
   input  logic [X_BITS-1:0]      dst_x,
   input  logic [Y_BITS-1:0]      dst_y,
   input  logic [1:0]             mode,
   input  logic                   flip_x,
   input  logic [COLOUR_BITS-1:0] fill_colour,
   output logic [SRC_AW-1:0]      src_addr,
   output logic                   src_rd,
   input  logic [COLOUR_BITS-1:0] src_data,
   output logic [X_BITS-1:0]      X_out,
   output logic [Y_BITS-1:0]      Y_out,
   output logic [COLOUR_BITS-1:0] colour,
   output logic                   write_en,
   output logic                   busy,
   output logic                   done
);

   // Extended coordinate widths so the clip compare sees the true sum
   localparam int unsigned CX_BITS = ((X_BITS > DIM_BITS) ? X_BITS : DIM_BITS) + 1;
   localparam int unsigned CY_BITS = ((Y_BITS > DIM_BITS) ? Y_BITS : DIM_BITS) + 1;
   localparam int unsigned DL_BITS = 3;

   localparam logic [1:0] MODE_COPY   = 2'b00;
   localparam logic [1:0] MODE_KEY    = 2'b01;
   localparam logic [1:0] MODE_SHADOW = 2'b10;
   localparam logic [1:0] MODE_FILL   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                 state_q;
   logic [SRC_AW-1:0]      base_q;
   logic [DIM_BITS-1:0]    stride_q, w_q, h_q;
   logic [X_BITS-1:0]      dx_q;
   logic [Y_BITS-1:0]      dy_q;
   logic [1:0]             mode_q;
   logic                   flip_q;
   logic [COLOUR_BITS-1:0] fill_q;

   logic [DIM_BITS-1:0]    col_q, row_q;
   logic [SRC_AW-1:0]      rowbase_q;
   logic [DL_BITS-1:0]     drain_q;

   logic [SRC_AW-1:0]      src_addr_q;
   logic                   src_rd_q, busy_q, done_q;

   // Stage 0 is the issue stage; stage READ_LATENCY meets src_data
   logic [X_BITS-1:0]      px_q [0:READ_LATENCY];
   logic [Y_BITS-1:0]      py_q [0:READ_LATENCY];
   logic                   pv_q [0:READ_LATENCY];

   logic [DIM_BITS-1:0]    col_src_d;
   logic [SRC_AW-1:0]      addr_d;
   logic [CX_BITS-1:0]     x_ext_d;
   logic [CY_BITS-1:0]     y_ext_d;
   logic                   on_scr_d, last_col_d, last_row_d;
   logic                   key_hit, wr_ok;
   logic [COLOUR_BITS-1:0] wr_colour;

   // Issue-stage address and coordinate arithmetic
   always_comb begin
      col_src_d  = flip_q ? (w_q - DIM_BITS'(1) - col_q) : col_q;
      addr_d     = base_q + rowbase_q + SRC_AW'(col_src_d);
      x_ext_d    = CX_BITS'(dx_q) + CX_BITS'(col_q);
      y_ext_d    = CY_BITS'(dy_q) + CY_BITS'(row_q);
      on_scr_d   = (x_ext_d < CX_BITS'(SCREEN_W)) && (y_ext_d < CY_BITS'(SCREEN_H));
      last_col_d = (col_q == w_q - DIM_BITS'(1));
      last_row_d = (row_q == h_q - DIM_BITS'(1));
   end

   // Write-stage mode decode against the returning source word
   always_comb begin
      key_hit   = (src_data == TRANSPARENT);
      wr_ok     = 1'b1;
      wr_colour = src_data;
      case (mode_q)
         MODE_COPY:   wr_ok = 1'b1;
         MODE_KEY:    wr_ok = !key_hit;
         MODE_SHADOW: begin
            wr_ok     = !key_hit;
            wr_colour = '0;
         end
         MODE_FILL:   wr_colour = fill_q;
         default:     wr_ok = 1'b1;
      endcase
   end

   // Control FSM, address generator and coordinate delay line
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         stride_q   <= '0;
         w_q        <= '0;
         h_q        <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         mode_q     <= MODE_COPY;
         flip_q     <= 1'b0;
         fill_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         rowbase_q  <= '0;
         drain_q    <= '0;
         src_addr_q <= '0;
         src_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
            px_q[i] <= '0;
            py_q[i] <= '0;
            pv_q[i] <= 1'b0;
         end
      end else begin
         done_q   <= 1'b0;
         src_rd_q <= 1'b0;
         pv_q[0]  <= 1'b0;
         busy_q   <= (state_q != S_IDLE);
         for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
            pv_q[i] <= pv_q[i-1];
         end

         case (state_q)
            S_IDLE: begin
               if (go) begin
                  base_q    <= src_base;
                  stride_q  <= src_stride;
                  w_q       <= blit_w;
                  h_q       <= blit_h;
                  dx_q      <= dst_x;
                  dy_q      <= dst_y;
                  mode_q    <= mode;
                  flip_q    <= flip_x;
                  fill_q    <= fill_colour;
                  col_q     <= '0;
                  row_q     <= '0;
                  rowbase_q <= '0;
                  drain_q   <= '0;
                  state_q   <= ((blit_w == '0) || (blit_h == '0)) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               src_addr_q <= addr_d;
               src_rd_q   <= (mode_q != MODE_FILL);
               px_q[0]    <= X_BITS'(x_ext_d);
               py_q[0]    <= Y_BITS'(y_ext_d);
               pv_q[0]    <= on_scr_d;
               // Row base accumulates the stride instead of multiplying
               if (last_col_d) begin
                  col_q     <= '0;
                  row_q     <= row_q + DIM_BITS'(1);
                  rowbase_q <= rowbase_q + SRC_AW'(stride_q);
               end else begin
                  col_q <= col_q + DIM_BITS'(1);
               end
               if (last_col_d && last_row_d) begin
                  drain_q <= '0;
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_q == DL_BITS'(READ_LATENCY - 1)) begin
                  state_q <= S_DONE;
               end else begin
                  drain_q <= drain_q + DL_BITS'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign src_addr = src_addr_q;
   assign src_rd   = src_rd_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign X_out    = px_q[READ_LATENCY];
   assign Y_out    = py_q[READ_LATENCY];
   // Data arrives with the final delay stage, so the strobe decodes it directly
   assign write_en = pv_q[READ_LATENCY] & wr_ok;
   assign colour   = pv_q[READ_LATENCY] ? wr_colour : '0;

endmodule

// File: tb/tb_blit_engine.sv
// Bench for blit_engine: two instances (read latency 1 and 3) share stimulus;
// each has its own source-memory latency model. Observed reads, writes, busy
// and done are logged per cycle and compared with a raster-order model.
module tb_blit_engine;

   localparam logic [5:0] KEY = 6'b001100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        go;
   logic [16:0] src_base;
   logic [8:0]  src_stride, blit_w, blit_h, dst_x;
   logic [7:0]  dst_y;
   logic [1:0]  mode;
   logic        flip_x;
   logic [5:0]  fill_colour;

   logic [16:0] addr_a, addr_b;
   logic        rd_a, rd_b, we_a, we_b, busy_a, busy_b, done_a, done_b;
   logic [5:0]  data_a, data_b, col_a, col_b;
   logic [8:0]  x_a, x_b;
   logic [7:0]  y_a, y_b;

   logic [5:0]  mem [0:131071];
   logic [16:0] ap_a [0:0];
   logic [16:0] ap_b [0:2];

   int cyc = 0;
   int n_cmp = 0;
   int n_mis = 0;

   logic [63:0] rd_log_a[$], rd_log_b[$], wr_log_a[$], wr_log_b[$];
   int          busy_log_a[$], busy_log_b[$], done_log_a[$], done_log_b[$];
   logic [63:0] got_rd[$], got_wr[$], exp_rd[$], exp_wr[$];
   int          got_busy[$], got_done[$];
   int          exp_done;

   int m_t0, m_base, m_stride, m_w, m_h, m_dx, m_dy, m_mode, m_flip, m_fill;

   blit_engine #(.READ_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset_n(reset_n), .go(go), .src_base(src_base),
      .src_stride(src_stride), .blit_w(blit_w), .blit_h(blit_h),
      .dst_x(dst_x), .dst_y(dst_y), .mode(mode), .flip_x(flip_x),
      .fill_colour(fill_colour), .src_addr(addr_a), .src_rd(rd_a),
      .src_data(data_a), .X_out(x_a), .Y_out(y_a), .colour(col_a),
      .write_en(we_a), .busy(busy_a), .done(done_a));

   blit_engine #(.READ_LATENCY(3)) u_dut_l3 (
      .clk(clk), .reset_n(reset_n), .go(go), .src_base(src_base),
      .src_stride(src_stride), .blit_w(blit_w), .blit_h(blit_h),
      .dst_x(dst_x), .dst_y(dst_y), .mode(mode), .flip_x(flip_x),
      .fill_colour(fill_colour), .src_addr(addr_b), .src_rd(rd_b),
      .src_data(data_b), .X_out(x_b), .Y_out(y_b), .colour(col_b),
      .write_en(we_b), .busy(busy_b), .done(done_b));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      ap_a[0] <= addr_a;
      ap_b[0] <= addr_b;
      ap_b[1] <= ap_b[0];
      ap_b[2] <= ap_b[1];
   end

   assign data_a = mem[ap_a[0]];
   assign data_b = mem[ap_b[2]];

   // Event logger, sampled on the falling edge
   always @(negedge clk) begin
      if (rd_a)   rd_log_a.push_back({32'(cyc), 32'(addr_a)});
      if (rd_b)   rd_log_b.push_back({32'(cyc), 32'(addr_b)});
      if (we_a)   wr_log_a.push_back({32'(cyc), 7'd0, x_a, y_a, 2'd0, col_a});
      if (we_b)   wr_log_b.push_back({32'(cyc), 7'd0, x_b, y_b, 2'd0, col_b});
      if (busy_a) busy_log_a.push_back(cyc);
      if (busy_b) busy_log_b.push_back(cyc);
      if (done_a) done_log_a.push_back(cyc);
      if (done_b) done_log_b.push_back(cyc);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      rd_log_a.delete(); rd_log_b.delete(); wr_log_a.delete(); wr_log_b.delete();
      busy_log_a.delete(); busy_log_b.delete(); done_log_a.delete(); done_log_b.delete();
   endtask

   // Reference: pixel k (raster order) read at t0+1+k, written at t0+1+k+rl
   task automatic build_exp(input int rl);
      int n, idx, c, x, y;
      logic [16:0] a;
      logic [5:0]  s, pc;
      bit          wr;
      exp_rd.delete();
      exp_wr.delete();
      n = m_w * m_h;
      for (int r = 0; r < m_h; r++) begin
         for (int k = 0; k < m_w; k++) begin
            idx = r * m_w + k;
            c   = (m_flip != 0) ? (m_w - 1 - k) : k;
            a   = 17'(m_base + r * m_stride + c);
            if (m_mode != 3) exp_rd.push_back({32'(m_t0 + 1 + idx), 32'(a)});
            x  = m_dx + k;
            y  = m_dy + r;
            s  = mem[a];
            wr = 1'b1;
            pc = s;
            if (m_mode == 1) wr = (s != KEY);
            if (m_mode == 2) begin wr = (s != KEY); pc = 6'd0; end
            if (m_mode == 3) pc = 6'(m_fill);
            if (x < 320 && y < 240 && wr)
               exp_wr.push_back({32'(m_t0 + 1 + idx + rl), 7'd0, 9'(x), 8'(y), 2'd0, pc});
         end
      end
      exp_done = (n == 0) ? m_t0 + 1 : m_t0 + n + rl + 1;
   endtask

   task automatic check_blit(input int d, input string nm);
      string p;
      int    rl;
      rl = (d == 0) ? 1 : 3;
      p  = $sformatf("%s.L%0d", nm, rl);
      build_exp(rl);
      if (d == 0) begin
         got_rd = rd_log_a; got_wr = wr_log_a; got_busy = busy_log_a; got_done = done_log_a;
      end else begin
         got_rd = rd_log_b; got_wr = wr_log_b; got_busy = busy_log_b; got_done = done_log_b;
      end
      check_val({p, ".nrd"}, 64'(got_rd.size()), 64'(exp_rd.size()));
      for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
         check_val($sformatf("%s.rd%0d", p, i), got_rd[i], exp_rd[i]);
      check_val({p, ".nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         check_val($sformatf("%s.wr%0d", p, i), got_wr[i], exp_wr[i]);
      check_val({p, ".ndone"}, 64'(got_done.size()), 64'd1);
      if (got_done.size() > 0) check_val({p, ".done_t"}, 64'(got_done[0]), 64'(exp_done));
      check_val({p, ".nbusy"}, 64'(got_busy.size()), 64'(exp_done - m_t0));
      if (got_busy.size() > 0) begin
         check_val({p, ".busy_first"}, 64'(got_busy[0]), 64'(m_t0 + 1));
         check_val({p, ".busy_last"}, 64'(got_busy[got_busy.size()-1]), 64'(exp_done));
      end
   endtask

   task automatic scramble();
      src_base    = 17'($urandom);
      src_stride  = 9'($urandom);
      blit_w      = 9'($urandom);
      blit_h      = 9'($urandom);
      dst_x       = 9'($urandom);
      dst_y       = 8'($urandom);
      mode        = 2'($urandom);
      flip_x      = 1'($urandom);
      fill_colour = 6'($urandom);
   endtask

   // One blit on both instances; extra=1 also pulses go mid-run and in the L1 DONE cycle
   task automatic run_blit(input string nm, input int base, input int stride, input int w,
                           input int h, input int dx, input int dy, input int md,
                           input int flip, input int fill, input bit extra);
      int n;
      @(posedge clk); #1;
      clear_logs();
      @(negedge clk);
      src_base = 17'(base); src_stride = 9'(stride); blit_w = 9'(w); blit_h = 9'(h);
      dst_x = 9'(dx); dst_y = 8'(dy); mode = 2'(md); flip_x = 1'(flip);
      fill_colour = 6'(fill);
      go = 1'b1;
      @(posedge clk); #1;
      m_t0 = cyc; m_base = base; m_stride = stride; m_w = w; m_h = h;
      m_dx = dx; m_dy = dy; m_mode = md; m_flip = flip; m_fill = fill;
      go = 1'b0;
      scramble();
      n = w * h;
      for (int c = 0; c < n + 12; c++) begin
         @(negedge clk);
         go = 1'b0;
         if (extra && (cyc == m_t0 + 2 || cyc == m_t0 + n + 1)) go = 1'b1;
      end
      go = 1'b0;
      check_blit(0, nm);
      check_blit(1, nm);
   endtask

   initial begin
      int placed, t0, late_a, late_b;
      int pos;
      logic [5:0] v;
      bit tile_key [0:255];

      for (int i = 0; i < 131072; i++)
         mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 6'($urandom);
      reset_n = 1'b0;
      go = 1'b0;
      scramble();
      repeat (3) @(negedge clk);
      check_val("rst.busy", {63'd0, busy_a | busy_b}, 64'd0);
      check_val("rst.done", {63'd0, done_a | done_b}, 64'd0);
      check_val("rst.we",   {63'd0, we_a | we_b}, 64'd0);
      check_val("rst.rd",   {63'd0, rd_a | rd_b}, 64'd0);
      check_val("rst.addr", {30'd0, addr_a, addr_b}, 64'd0);
      check_val("rst.xy",   {30'd0, x_a, y_a, x_b, y_b}, 64'd0);
      check_val("rst.col",  {52'd0, col_a, col_b}, 64'd0);
      reset_n = 1'b1;

      // Basic copy; L1 done at T+10, L3 at T+12
      run_blit("copy4x2", 100, 320, 4, 2, 10, 20, 0, 0, 0, 1'b0);
      check_val("copy4x2.done_l1", (done_log_a.size() > 0) ? 64'(done_log_a[0]) : 64'd0, 64'(m_t0 + 10));
      check_val("copy4x2.done_l3", (done_log_b.size() > 0) ? 64'(done_log_b[0]) : 64'd0, 64'(m_t0 + 12));

      // 16x16 keyed tile with exactly 40 transparent pixels
      for (int i = 0; i < 256; i++) begin
         tile_key[i] = 1'b0;
         do v = 6'($urandom); while (v == KEY);
         mem[1056 + (i / 16) * 64 + (i % 16)] = v;
      end
      placed = 0;
      while (placed < 40) begin
         pos = $urandom_range(0, 255);
         if (!tile_key[pos]) begin
            tile_key[pos] = 1'b1;
            mem[1056 + (pos / 16) * 64 + (pos % 16)] = KEY;
            placed++;
         end
      end
      run_blit("key16", 1056, 64, 16, 16, 100, 50, 1, 0, 0, 1'b0);
      check_val("key16.count", 64'(wr_log_a.size()), 64'd216);

      run_blit("flip3", 0, 5, 3, 1, 40, 40, 0, 1, 0, 1'b0);
      check_val("flip3.first_addr", (rd_log_a.size() > 0) ? 64'(rd_log_a[0][31:0]) : 64'hff, 64'd2);

      mem[5000] = 6'd1; mem[5001] = 6'd2; mem[5002] = KEY; mem[5003] = 6'd3;
      run_blit("shadow2x2", 5000, 2, 2, 2, 7, 9, 2, 0, 0, 1'b0);
      check_val("shadow2x2.count", 64'(wr_log_a.size()), 64'd3);

      run_blit("fill5x3", 777, 100, 5, 3, 0, 0, 3, 0, 6'h2A, 1'b0);
      check_val("fill5x3.count", 64'(wr_log_a.size()), 64'd15);
      check_val("fill5x3.reads", 64'(rd_log_a.size() + rd_log_b.size()), 64'd0);

      run_blit("clip", 200, 320, 4, 2, 318, 239, 0, 0, 0, 1'b0);
      check_val("clip.count", 64'(wr_log_a.size()), 64'd2);

      run_blit("zero_w", 300, 10, 0, 5, 10, 10, 0, 0, 0, 1'b0);
      run_blit("zero_h", 300, 10, 5, 0, 10, 10, 1, 0, 0, 1'b0);
      run_blit("go_busy", 4000, 37, 6, 4, 150, 100, 0, 0, 0, 1'b1);
      run_blit("wrap", 131070, 7, 5, 3, 60, 60, 0, 1, 0, 1'b0);

      // Reset in the middle of RUN: outputs drop next cycle, no done follows
      @(posedge clk); #1;
      clear_logs();
      @(negedge clk);
      src_base = 17'd2000; src_stride = 9'd64; blit_w = 9'd8; blit_h = 9'd8;
      dst_x = 9'd5; dst_y = 8'd5; mode = 2'd0; flip_x = 1'b0; go = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      go = 1'b0;
      while (cyc < t0 + 4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_val("rst_run.we",   {62'd0, we_a, we_b}, 64'd0);
      check_val("rst_run.busy", {62'd0, busy_a, busy_b}, 64'd0);
      check_val("rst_run.rd",   {62'd0, rd_a, rd_b}, 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (80) @(negedge clk);
      check_val("rst_run.done", 64'(done_log_a.size() + done_log_b.size()), 64'd0);
      late_a = 0;
      late_b = 0;
      foreach (wr_log_a[i]) if (int'(wr_log_a[i][63:32]) >= t0 + 5) late_a++;
      foreach (wr_log_b[i]) if (int'(wr_log_b[i][63:32]) >= t0 + 5) late_b++;
      check_val("rst_run.late_wr", 64'(late_a + late_b), 64'd0);
      check_val("rst_run.pre_wr_l1", 64'(wr_log_a.size()), 64'd3);
      check_val("rst_run.pre_wr_l3", 64'(wr_log_b.size()), 64'd1);

      // Randomised blits, biased towards the screen edges and address wrap
      for (int it = 0; it < 25; it++) begin
         int rw, rh, rx, ry;
         rw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10);
         rh = $urandom_range(1, 8);
         rx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 511) : $urandom_range(310, 325);
         ry = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(230, 245);
         run_blit($sformatf("rnd%0d", it), $urandom_range(0, 131071), $urandom_range(0, 511),
                  rw, rh, rx, ry, $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 63), 1'($urandom_range(0, 1)) && (rw * rh >= 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
